reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one 8-bit enabled storage register among several requesters. It sits between the requesting blocks and the register. It accepts level requests, picks one winner per transaction, captures that winner's data and performs a single enabled write. It then returns a one-cycle acknowledge to the winner and advances the priority pointer. It also exposes the stored value, the current owner and a wrapping write counter for debug.

---
 rtl/reg_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 tb/tb_reg_write_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
package reg_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  // IDLE: arbitrate and capture; WRITE: load q; DONE: acknowledge and advance ptr.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  // Walk the requesters starting at ptr and take the first one that is asking.
  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    any_req   = |req;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a single enabled storage register.
// One transaction is IDLE (capture) -> WRITE (load q) -> DONE (ack, advance ptr).
//
// Handshake: a requester raises req[i] with data[i] valid and holds both until
// it sees ack[i]; ack[i] is a one-cycle pulse meaning the write has landed in q.
// The requester must drop req[i] by the edge that ends the ack cycle, otherwise
// the still-high level is taken as a fresh request in the following IDLE.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic                   wr_en,
  output logic [2:0]             owner,
  output logic                   busy,
  output logic [7:0]             write_count,
  output logic [1:0]             dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       count_q, count_d;

  logic [N_REQ-1:0] grant;
  logic [2:0]       grant_idx;
  logic             any_req;
  logic [WIDTH-1:0] hold_sel;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // One-hot grant selects the winner's data word.
  always_comb begin
    hold_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) hold_sel = hold_sel | data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state logic: all registers hold unless the current state moves them.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = grant_idx;
          hold_d  = hold_sel;
          state_d = WRITE;
        end
      end
      WRITE: begin
        q_d     = hold_q;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
        count_d = count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      q_q     <= '0;
      owner_q <= 3'd0;
      ptr_q   <= 3'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Strobes are decoded from the state register only, never from req.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ack[i] = (state_q == DONE) && (owner_q == 3'(i));
    end
    wr_en       = (state_q == WRITE);
    busy        = (state_q != IDLE);
    q           = q_q;
    owner       = owner_q;
    write_count = count_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           rst   = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] data  = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           wr_en;
  logic [2:0]     owner;
  logic           busy;
  logic [7:0]     write_count;
  logic [1:0]     dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock       (clock),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .q           (q),
    .wr_en       (wr_en),
    .owner       (owner),
    .busy        (busy),
    .write_count (write_count),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a transaction is "cycles left" after capture (2 = write
  // cycle, 1 = ack cycle, 0 = free), with the winner found by a modular search.
  int         m_left  = 0;
  int         m_owner = 0;
  int         m_ptr   = 0;
  logic [7:0] m_hold  = '0;
  logic [7:0] m_q     = '0;
  logic [7:0] m_cnt   = '0;

  task automatic model_edge();
    int idx;
    if (!rst) begin
      m_left = 0; m_owner = 0; m_ptr = 0; m_hold = '0; m_q = '0; m_cnt = '0;
    end else if (m_left == 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (m_ptr + k) % N;
        if (req[idx]) begin
          m_owner = idx;
          m_left  = 2;
        end
      end
      if (m_left == 2) m_hold = data[m_owner*W +: W];
    end else if (m_left == 2) begin
      m_q    = m_hold;
      m_left = 1;
    end else begin
      m_ptr  = (m_owner + 1) % N;
      m_cnt  = m_cnt + 8'd1;
      m_left = 0;
    end
  endtask

  // One clock: advance model with the inputs present at the edge, then compare.
  task automatic cycle();
    logic [N-1:0] e_ack;
    state_t       e_st;
    @(posedge clock);
    model_edge();
    #1;
    e_ack = (m_left == 1) ? N'(1 << m_owner) : '0;
    e_st  = (m_left == 0) ? IDLE : ((m_left == 2) ? WRITE : DONE);
    chk("m_q",     32'(q),           32'(m_q));
    chk("m_ack",   32'(ack),         32'(e_ack));
    chk("m_wr_en", 32'(wr_en),       32'(m_left == 2));
    chk("m_busy",  32'(busy),        32'(m_left != 0));
    chk("m_owner", 32'(owner),       32'(m_owner));
    chk("m_count", 32'(write_count), 32'(m_cnt));
    chk("m_state", 32'(dbg_state),   32'(e_st));
  endtask

  // Directed-sequence helpers
  int ord[300];
  int got;

  task automatic run_until_acks(input int n, input int budget, input bit keep_req);
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      cycle();
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) ord[got] = i;
        got++;
        if (!keep_req || got == n) req = req & ~ack;
      end
    end
    chk("ack_budget", 32'(got), 32'(n));
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  q;
    logic [3:0]  ack;
    logic        wr_en;
    logic        busy;
    logic [2:0]  owner;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // rst, req, data, | q, ack, wr_en, busy, owner, count
    tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0000, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[2]  = '{1'b1, 4'h0, 32'h0000_0000, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0};
    // single write from requester 2
    tbl[3]  = '{1'b1, 4'h4, 32'h00A5_0000, 8'h00, 4'h0, 1'b1, 1'b1, 3'd2, 8'd0};
    tbl[4]  = '{1'b1, 4'h4, 32'h00A5_0000, 8'hA5, 4'h4, 1'b0, 1'b1, 3'd2, 8'd0};
    tbl[5]  = '{1'b1, 4'h0, 32'h00A5_0000, 8'hA5, 4'h0, 1'b0, 1'b0, 3'd2, 8'd1};
    // data[0] changes 11 -> 22 during WRITE; captured 11 is written
    tbl[6]  = '{1'b1, 4'h1, 32'h0000_0011, 8'hA5, 4'h0, 1'b1, 1'b1, 3'd0, 8'd1};
    tbl[7]  = '{1'b1, 4'h1, 32'h0000_0022, 8'h11, 4'h1, 1'b0, 1'b1, 3'd0, 8'd1};
    tbl[8]  = '{1'b1, 4'h0, 32'h0000_0022, 8'h11, 4'h0, 1'b0, 1'b0, 3'd0, 8'd2};
    // reset during WRITE aborts: no ack, everything back to zero
    tbl[9]  = '{1'b1, 4'h1, 32'h0000_0033, 8'h11, 4'h0, 1'b1, 1'b1, 3'd0, 8'd2};
    tbl[10] = '{1'b0, 4'h1, 32'h0000_0033, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0};
    tbl[11] = '{1'b1, 4'h0, 32'h0000_0000, 8'h00, 4'h0, 1'b0, 1'b0, 3'd0, 8'd0};

    for (int i = 0; i < 12; i++) begin
      rst  = tbl[i].rst;
      req  = tbl[i].req;
      data = tbl[i].data;
      cycle();
      chk("tbl_q",     32'(q),           32'(tbl[i].q));
      chk("tbl_ack",   32'(ack),         32'(tbl[i].ack));
      chk("tbl_wr_en", 32'(wr_en),       32'(tbl[i].wr_en));
      chk("tbl_busy",  32'(busy),        32'(tbl[i].busy));
      chk("tbl_owner", 32'(owner),       32'(tbl[i].owner));
      chk("tbl_count", 32'(write_count), 32'(tbl[i].cnt));
    end

    // Idle after reset: nothing moves for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_q",    32'(q),           32'h0);
      chk("idle_ack",  32'(ack),         32'h0);
      chk("idle_busy", 32'(busy),        32'h0);
      chk("idle_cnt",  32'(write_count), 32'h0);
    end

    // Round-robin with all four requesting from ptr = 0
    data = {8'h04, 8'h03, 8'h02, 8'h01};
    req  = 4'hF;
    run_until_acks(4, 40, 1'b0);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(ord[i]), 32'(i));
    chk("rr_final_q", 32'(q), 32'h04);
    cycle();
    chk("rr_count", 32'(write_count), 32'd4);

    // Serve requester 1 alone: ptr becomes 2
    req = 4'h2;
    data[15:8] = 8'h5A;
    run_until_acks(1, 20, 1'b0);
    chk("ptr_serve1", 32'(ord[0]), 32'd1);
    cycle();
    // With ptr = 2 the search visits 2, 3, 0, 1: requester 0 wins, then 1
    req = 4'h3;
    run_until_acks(2, 30, 1'b0);
    chk("ptr_first",  32'(ord[0]), 32'd0);
    chk("ptr_second", 32'(ord[1]), 32'd1);
    cycle();

    // Counter wrap: 256 back-to-back writes with req held high
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    req = 4'h8;
    data[31:24] = 8'(($urandom));
    run_until_acks(256, 1000, 1'b1);
    cycle();
    chk("wrap_count", 32'(write_count), 32'd0);
    chk("wrap_busy",  32'(busy),        32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      cycle();
      req = req & ~ack;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          data[i*W +: W] = 8'($urandom);
        end
      end
      if ($urandom_range(5) == 0) data[$urandom_range(N-1)*W +: W] = 8'($urandom);
      rst = ($urandom_range(63) != 0);
    end

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
